// File: rtl/cpu_host_ctrl_pkg.sv
// Shared types and widths for the CPU host controller.
// Holds the host command encoding, the controller state encoding and the
// instruction/data word widths used by cpu_host_ctrl and its output register.
package cpu_host_ctrl_pkg;

  localparam int INSTR_W = 9;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 10;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [1:0] {
    CMD_LOAD_I = 2'd0,
    CMD_LOAD_D = 2'd1,
    CMD_RUN    = 2'd2,
    CMD_DUMP   = 2'd3
  } host_cmd_e;

  // Controller states; ST_ prefix keeps them apart from the command names.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_I,
    ST_LOAD_D,
    ST_START,
    ST_WAIT,
    ST_DUMP_RD,
    ST_DUMP_OUT
  } host_state_e;

endpackage

// File: rtl/cpu_host_ctrl_out_reg.sv
// Valid/ready holding register for the dump byte stream.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   load, din    capture din and raise valid
//   ready        downstream accepts the held byte
//   valid, dout  registered output byte and its valid flag
module cpu_host_ctrl_out_reg
  import cpu_host_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  // dout only changes on load, so it is stable for as long as valid waits on ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host-side controller for the CPU core: preloads instruction and data memory,
// pulses start, waits for done (or a timeout) and streams a data memory window out.
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   cmd_valid/ready/op/addr/len   command channel (accepted only in IDLE)
//   in_valid/ready/data           load word channel (LOAD_I / LOAD_D)
//   out_valid/ready/data          dump byte channel
//   imem_we/addr/wdata            instruction memory write port
//   dmem_we/addr/wdata/rdata      data memory port, combinational read
//   start, done                   CPU start/initialise and completion
//   busy, timeout_err             status; timeout_err is sticky until reset or next RUN
// Optional feature macro CPU_HOST_CYCLE_COUNT_EN adds output run_cycles[15:0],
// the WAIT cycle count latched at done (or the timeout value on timeout).
module cpu_host_ctrl
  import cpu_host_ctrl_pkg::*;
#(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 65535,
  parameter int IMEM_AW      = 10,
  parameter int DMEM_AW      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               start,
  input  logic               done,
  output logic               busy,
  output logic               timeout_err
`ifdef CPU_HOST_CYCLE_COUNT_EN
  ,
  output logic [15:0]        run_cycles
`endif
);

  host_state_e        state_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [15:0]        cyc_q;
  logic               timeout_q;
  logic               dump_load;
  logic               wait_last;
  logic               wait_hit_timeout;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D);
  assign busy        = (state_q != ST_IDLE);
  assign start       = (state_q == ST_START);
  assign timeout_err = timeout_q;

  // Writes go straight through in the handshake cycle; reset suppresses a
  // write that would otherwise land on the same edge that aborts the load.
  assign imem_we    = (state_q == ST_LOAD_I) && in_valid && !reset;
  assign dmem_we    = (state_q == ST_LOAD_D) && in_valid && !reset;
  assign imem_addr  = addr_q;
  assign imem_wdata = imem_we ? in_data : '0;
  assign dmem_addr  = addr_q[DMEM_AW-1:0];
  assign dmem_wdata = dmem_we ? in_data[DATA_W-1:0] : '0;

  assign dump_load        = (state_q == ST_DUMP_RD);
  assign wait_hit_timeout = (cyc_q + 16'd1 == 16'(TIMEOUT));
  // done wins over the timeout when both land on the final WAIT cycle.
  assign wait_last        = (state_q == ST_WAIT) && (done || wait_hit_timeout);

  // Main controller. cyc_q counts START cycles first, then is cleared and
  // reused to count WAIT cycles for the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            cnt_q  <= cmd_len;
            cyc_q  <= '0;
            unique case (host_cmd_e'(cmd_op))
              CMD_LOAD_I: state_q <= ST_LOAD_I;
              CMD_LOAD_D: state_q <= ST_LOAD_D;
              CMD_RUN: begin
                state_q   <= ST_START;
                timeout_q <= 1'b0;
              end
              CMD_DUMP:   state_q <= ST_DUMP_RD;
            endcase
          end
        end
        ST_LOAD_I, ST_LOAD_D: begin
          if (in_valid) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= ST_IDLE;
          end
        end
        ST_START: begin
          if (cyc_q == 16'(START_CYCLES - 1)) begin
            cyc_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            cyc_q <= cyc_q + 16'd1;
          end
        end
        ST_WAIT: begin
          if (done) begin
            state_q <= ST_IDLE;
          end else if (wait_hit_timeout) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cyc_q <= cyc_q + 16'd1;
          end
        end
        ST_DUMP_RD: state_q <= ST_DUMP_OUT;
        ST_DUMP_OUT: begin
          if (out_ready) begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              cnt_q   <= cnt_q - 1'b1;
              state_q <= ST_DUMP_RD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CPU_HOST_CYCLE_COUNT_EN
  logic [15:0] run_q;

  // On the last WAIT cycle cyc_q+1 is the number of WAIT cycles spent,
  // which equals TIMEOUT when the run was aborted.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= '0;
    end else if (wait_last) begin
      run_q <= cyc_q + 16'd1;
    end
  end

  assign run_cycles = run_q;
`endif

  cpu_host_ctrl_out_reg u_out_reg (
    .clk   (clk),
    .reset (reset),
    .load  (dump_load),
    .din   (dmem_rdata),
    .ready (out_ready),
    .valid (out_valid),
    .dout  (out_data)
  );

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Self-checking bench for cpu_host_ctrl: directed scenarios followed by a
// randomized command mix, checked against a simple behavioural model.
module tb_cpu_host_ctrl;
  import cpu_host_ctrl_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [9:0] cmd_addr;
  logic [9:0] cmd_len;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       imem_we;
  logic [9:0] imem_addr;
  logic [8:0] imem_wdata;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic [7:0] dmem_rdata;
  logic       start;
  logic       done;
  logic       busy;
  logic       timeout_err;
`ifdef CPU_HOST_CYCLE_COUNT_EN
  logic [15:0] run_cycles;
`endif

  int test_count = 0;
  int fail_count = 0;

  logic [8:0] imem_mem [1024];
  logic [7:0] dmem_mem [256];
  logic [7:0] ref_dmem [256];
  logic [8:0] word_buf [1024];

  cpu_host_ctrl #(.START_CYCLES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .start(start), .done(done), .busy(busy), .timeout_err(timeout_err)
`ifdef CPU_HOST_CYCLE_COUNT_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Memories the DUT writes into; data memory reads back combinationally.
  always @(posedge clk) begin
    if (imem_we) imem_mem[imem_addr] <= imem_wdata;
    if (dmem_we) dmem_mem[dmem_addr] <= dmem_wdata;
  end
  assign dmem_rdata = dmem_mem[dmem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Presents one command in IDLE and returns just after it is accepted.
  task automatic applyStimulus(input logic [1:0] op, input logic [9:0] addr, input logic [9:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
    #1;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 10'($urandom); cmd_len = 10'($urandom);
    checkOutput("busy_after_accept", 32'({busy, cmd_ready}), 32'(2'b10));
  endtask

  task automatic fillWords(input int len);
    for (int i = 0; i <= len; i++) word_buf[i] = 9'($urandom);
  endtask

  // Loads word_buf[0..len] starting at addr; optional idle gaps between words.
  task automatic loadWords(input bit to_imem, input logic [9:0] addr, input int len, input bit gaps);
    int a;
    applyStimulus(to_imem ? CMD_LOAD_I : CMD_LOAD_D, addr, 10'(len));
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        in_valid = 1'b0; in_data = 9'($urandom);
        #1;
        checkOutput("load_gap", 32'({in_ready, imem_we, dmem_we}), 32'(3'b100));
      end
      @(negedge clk);
      in_valid = 1'b1; in_data = word_buf[i];
      #1;
      if (to_imem) begin
        a = (int'(addr) + i) % 1024;
        checkOutput("imem_write", 32'({imem_we, dmem_we, imem_addr, imem_wdata}),
                    32'({2'b10, 10'(a), word_buf[i]}));
      end else begin
        a = (int'(addr) + i) % 256;
        checkOutput("dmem_write", 32'({imem_we, dmem_we, dmem_addr, dmem_wdata}),
                    32'({2'b01, 8'(a), word_buf[i][7:0]}));
        ref_dmem[a] = word_buf[i][7:0];
      end
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 9'($urandom);
    #1;
    checkOutput("load_end", 32'({cmd_ready, in_ready, busy, imem_we, dmem_we}), 32'(5'b10000));
    in_valid = 1'b0;
  endtask

  // RUN with done held high from WAIT cycle done_at onward (0 = never).
  task automatic runCpu(input int done_at, input bit done_early);
    int  fin;
    bit  exp_to;
    exp_to = !(done_at != 0 && done_at <= TO);
    fin    = exp_to ? TO : done_at;
    applyStimulus(CMD_RUN, 10'($urandom), 10'($urandom));
    for (int k = 1; k <= 2 + fin + 1; k++) begin
      @(negedge clk);
      if (k <= 2) done = done_early;
      else        done = (done_at != 0) && (k - 2 >= done_at);
      in_valid = 1'($urandom); in_data = 9'($urandom);
      #1;
      checkOutput("run_start", 32'(start), 32'(k <= 2));
      checkOutput("run_busy", 32'({busy, cmd_ready}), (k <= 2 + fin) ? 32'(2'b10) : 32'(2'b01));
      checkOutput("run_we", 32'({imem_we, dmem_we}), 32'(0));
      checkOutput("timeout_err", 32'(timeout_err), (k > 2 + fin) ? 32'(exp_to) : 32'(0));
    end
`ifdef CPU_HOST_CYCLE_COUNT_EN
    checkOutput("run_cycles", 32'(run_cycles), 32'(fin));
`endif
    done = 1'b0; in_valid = 1'b0;
  endtask

  // DUMP of len+1 bytes; mode 0 toggles out_ready 1/0, mode 1 randomizes it.
  task automatic dumpWindow(input logic [9:0] addr, input int len, input int mode);
    int         idx;
    int         cyc;
    bit         stalled;
    bit         gap;
    logic [7:0] held;
    logic [7:0] want;
    idx = 0; cyc = 0; stalled = 0; gap = 0; held = '0;
    applyStimulus(CMD_DUMP, addr, 10'(len));
    while (idx <= len && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = (mode == 0) ? 1'(cyc % 2) : 1'($urandom);
      in_valid  = 1'($urandom);
      #1;
      want = ref_dmem[(int'(addr[7:0]) + idx) % 256];
      checkOutput("dump_ctl", 32'({imem_we, dmem_we, start, busy}), 32'(4'b0001));
      if (gap)     checkOutput("dump_gap", 32'(out_valid), 32'(0));
      if (stalled) checkOutput("dump_hold", 32'({out_valid, out_data}), 32'({1'b1, held}));
      gap = 0; stalled = 0;
      if (out_valid) begin
        checkOutput("dump_data", 32'(out_data), 32'(want));
        if (out_ready) begin
          idx++;
          gap = (idx <= len);
        end else begin
          stalled = 1;
          held    = want;
        end
      end
    end
    checkOutput("dump_count", 32'(idx), 32'(len + 1));
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("dump_end", 32'({cmd_ready, busy, out_valid}), 32'(3'b100));
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_state",
                32'({cmd_ready, in_ready, busy, start, out_valid, timeout_err, imem_we, dmem_we}),
                32'(8'b1000_0000));
    checkOutput("reset_data", 32'({out_data, dmem_addr, imem_addr}), 32'(0));

    // Directed LOAD_I.
    word_buf[0] = 9'h1A5; word_buf[1] = 9'h0FF; word_buf[2] = 9'h100;
    loadWords(1'b1, 10'd0, 2, 1'b0);

    // Give every data memory byte a known value.
    fillWords(255);
    loadWords(1'b0, 10'd0, 255, 1'b0);

    // LOAD_D wrapping past 0xFF.
    word_buf[0] = 9'h011; word_buf[1] = 9'h022; word_buf[2] = 9'h033;
    loadWords(1'b0, 10'h0FE, 2, 1'b0);

    // RUN variants: normal, timeout, clear by next RUN, done already high, last-cycle done.
    runCpu(5, 1'b0);
    runCpu(0, 1'b0);
    runCpu(3, 1'b0);
    runCpu(1, 1'b1);
    runCpu(TO, 1'b1);
    runCpu(TO + 1, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    checkOutput("reset_clears_timeout", 32'(timeout_err), 32'(0));

    // Directed DUMP with out_ready toggling.
    word_buf[0] = 9'h0A0; word_buf[1] = 9'h0A1; word_buf[2] = 9'h0A2; word_buf[3] = 9'h0A3;
    loadWords(1'b0, 10'h010, 3, 1'b0);
    dumpWindow(10'h010, 3, 0);

    // Reset in the middle of LOAD_D, after one of four words.
    fillWords(3);
    applyStimulus(CMD_LOAD_D, 10'h040, 10'd3);
    @(negedge clk);
    in_valid = 1'b1; in_data = word_buf[0];
    #1;
    checkOutput("dmem_write", 32'({dmem_we, dmem_addr, dmem_wdata}), 32'({1'b1, 8'h40, word_buf[0][7:0]}));
    ref_dmem[8'h40] = word_buf[0][7:0];
    @(negedge clk);
    reset = 1'b1; in_data = word_buf[1];
    #1;
    checkOutput("reset_no_we", 32'({imem_we, dmem_we}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_idle", 32'({cmd_ready, busy, in_ready, dmem_we}), 32'(4'b1000));
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_mem", 32'(dmem_mem[8'h41]), 32'(ref_dmem[8'h41]));

    // Randomized command mix.
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0: begin
          fillWords(15);
          loadWords(1'b1, 10'($urandom), $urandom_range(0, 15), 1'b1);
        end
        1: begin
          fillWords(15);
          loadWords(1'b0, 10'($urandom), $urandom_range(0, 15), 1'b1);
        end
        2: runCpu($urandom_range(0, TO + 4), 1'($urandom));
        default: dumpWindow(10'($urandom), $urandom_range(0, 15), $urandom_range(0, 1));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
